spi_slave: RTL and testbench

- SPI slave (responder) for the single-slave SPI link; mode 0 (CPOL=0, CPHA=0), MSB first, active-low slave select.
- Oversamples the master's sclk/ss/mosi in the local clk domain.
- Shifts out a host-supplied transmit word while capturing the master's word.
- Presents the received word to local logic with a one-cycle valid pulse; sits between the SPI pins and the local register/datapath logic.

---
 rtl/spi_slave.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first, active-low slave select.
// sclk/ss/mosi are oversampled in the clk domain; a one-deep tx buffer feeds
// each frame and every complete received word is presented with a one-cycle
// rx_valid pulse.
// Optional build macro SPI_SLAVE_OVERRUN_EN adds rx_ack/rx_overrun.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no frame; miso held low, waiting for ss falling edge
// SHIFT | frame in progress; sample mosi on sclk rise, shift miso on fall
// DONE  | full word received; sclk ignored until ss rises
module spi_slave #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_TX_WORD = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic                  rx_ack,
    output logic                  rx_overrun
`endif
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic                   tx_full;
    logic [DATA_WIDTH-1:0]  tx_buf;
    logic [DATA_WIDTH-1:0]  load_word;
    logic [DATA_WIDTH-2:0]  tx_shift;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_word;
    logic [CNT_W-1:0]       bit_cnt;

    logic frame_start, sample_rx, shift_tx, frame_done, to_idle;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    assign load_word = tx_full ? tx_buf : IDLE_TX_WORD;
    assign rx_word   = {rx_shift, mosi_s};
    assign tx_ready  = ~tx_full;
    assign busy      = (state_q != IDLE);

    // Synchronize the pins and keep one extra delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and datapath strobes; ss rise outranks a coincident sclk rise.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        sample_rx   = 1'b0;
        shift_tx    = 1'b0;
        frame_done  = 1'b0;
        to_idle     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d     = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    to_idle = 1'b1;
                end else if (sclk_rise) begin
                    sample_rx = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d    = DONE;
                        frame_done = 1'b1;
                    end
                end else if (sclk_fall) begin
                    shift_tx = 1'b1;
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    to_idle = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                to_idle = 1'b1;
            end
        endcase
    end

    // Shift registers, bit counter, miso and the received-word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            miso     <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= frame_done;
            if (frame_start) begin
                miso     <= load_word[DATA_WIDTH-1];
                tx_shift <= load_word[DATA_WIDTH-2:0];
                bit_cnt  <= '0;
            end else if (to_idle) begin
                miso <= 1'b0;
            end else if (shift_tx) begin
                miso     <= tx_shift[DATA_WIDTH-2];
                tx_shift <= tx_shift << 1;
            end
            if (sample_rx) begin
                rx_shift <= rx_word[DATA_WIDTH-2:0];
                bit_cnt  <= bit_cnt + 1'b1;
            end
            if (frame_done) rx_data <= rx_word;
        end
    end

    // One-deep tx buffer: emptied at frame start, refilled by handshake.
    // An accept in the frame-start cycle lands in the buffer for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else begin
            if (frame_start) tx_full <= 1'b0;
            if (tx_valid && !tx_full) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_unacked;

    // Sticky overrun: a new word arrives while the previous one is unread.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_unacked <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_valid)    rx_unacked <= 1'b1;
            else if (rx_ack) rx_unacked <= 1'b0;
            if (rx_valid && rx_unacked) rx_overrun <= 1'b1;
            else if (rx_ack && !rx_valid) rx_overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_spi_slave;

    localparam int HALF = 4;   // sclk half period in clk cycles (clk/8)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_ack = 1'b0;
    logic       rx_overrun;
`endif

    int checks = 0;
    int failures = 0;
    int rv_total = 0;

    // frame-level reference model state
    bit         m_pending = 1'b0;
    logic [7:0] m_buf = 8'h00;
    logic [7:0] m_rx = 8'h00;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_TX_WORD(8'h00)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
        , .rx_ack(rx_ack), .rx_overrun(rx_overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && rx_valid) rv_total++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_drop", tx_ready, 0);
    endtask

    // Master side of one frame; optionally raises ss together with the last
    // sclk rise, or injects a tx handshake in the frame-start cycle.
    task automatic spi_frame(input logic [7:0] w, input int nbits, input bit sim_last,
                             input bit inj, input logic [7:0] inj_word,
                             output logic [7:0] got);
        got = 8'h00;
        @(negedge clk);
        ss   = 1'b0;
        mosi = w[7];
        for (int k = 0; k < HALF + 1; k++) begin
            @(negedge clk);
            if (inj && k == 1) begin
                tx_data  = inj_word;
                tx_valid = 1'b1;
            end
            if (inj && k == 2) tx_valid = 1'b0;
        end
        chk("busy_mid", busy, 1);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            got  = {got[6:0], miso};
            if (sim_last && i == nbits - 1) ss = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            if (i < 7) mosi = w[6-i];
            repeat (HALF) @(negedge clk);
        end
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] w, input int nbits,
                            input bit sim_last, input bit inj, input logic [7:0] inj_word,
                            input logic [7:0] exp_miso, input int exp_cnt,
                            input logic [7:0] exp_rx);
        logic [7:0] got;
        int v0;
        v0 = rv_total;
        spi_frame(w, nbits, sim_last, inj, inj_word, got);
        chk({tag, "_master_rx"}, got, exp_miso >> (8 - nbits));
        chk({tag, "_rx_valid_cnt"}, rv_total - v0, exp_cnt);
        chk({tag, "_rx_data"}, rx_data, exp_rx);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_miso_idle"}, miso, 0);
        chk({tag, "_tx_ready_end"}, tx_ready, inj ? 0 : 1);
    endtask

    typedef struct {
        bit         load;
        logic [7:0] tx;
        logic [7:0] mosi_w;
        int         nbits;
        logic [7:0] exp_miso;
        int         exp_cnt;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] w, t, em;
        int nb;
        bit ld;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8, 8'hA5, 1, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8, 8'h00, 1, 8'hFF};
        vecs[2] = '{1'b0, 8'h00, 8'hF0, 4, 8'h00, 0, 8'hFF};
        vecs[3] = '{1'b0, 8'h00, 8'h81, 8, 8'h00, 1, 8'h81};
        vecs[4] = '{1'b1, 8'h56, 8'h12, 8, 8'h56, 1, 8'h12};
        vecs[5] = '{1'b1, 8'h78, 8'h34, 8, 8'h78, 1, 8'h34};

        repeat (4) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // directed vector table
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].load) push_tx(vecs[v].tx);
            do_frame($sformatf("vec%0d", v), vecs[v].mosi_w, vecs[v].nbits, 1'b0, 1'b0, 8'h00,
                     vecs[v].exp_miso, vecs[v].exp_cnt, vecs[v].exp_rx);
        end
        m_rx = 8'h34;

        // handshake in the frame-start cycle: current frame sends idle word
        do_frame("start_accept", 8'h5D, 8, 1'b0, 1'b1, 8'hC3, 8'h00, 1, 8'h5D);
        m_rx = 8'h5D;

        // ss rise together with final sclk rise: abort, buffered word consumed
        do_frame("ss_wins", 8'hE7, 8, 1'b1, 1'b0, 8'h00, 8'hC3, 0, 8'h5D);
        do_frame("after_ss_wins", 8'h2B, 8, 1'b0, 1'b0, 8'h00, 8'h00, 1, 8'h2B);

        // reset during bit 5 of a frame
        push_tx(8'hEE);
        @(negedge clk);
        ss   = 1'b0;
        mosi = 1'b1;
        repeat (HALF + 1) @(negedge clk);
        push_tx(8'h11);
        w = 8'hB7;
        for (int i = 0; i < 5; i++) begin
            mosi = w[7-i];
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 4) begin
                sclk = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
        chk("pre_rst_miso", miso, 1);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_miso", miso, 0);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        ss   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        m_pending = 1'b0;
        m_rx = 8'h00;
        push_tx(8'h66);
        do_frame("post_rst", 8'h99, 8, 1'b0, 1'b0, 8'h00, 8'h66, 1, 8'h99);
        m_rx = 8'h99;

        // randomized frames against the model
        for (int r = 0; r < 16; r++) begin
            ld = 1'($urandom_range(0, 1));
            t  = 8'($urandom);
            w  = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            if (ld) begin
                push_tx(t);
                m_pending = 1'b1;
                m_buf = t;
            end
            em = m_pending ? m_buf : 8'h00;
            m_pending = 1'b0;
            if (nb == 8) m_rx = w;
            do_frame($sformatf("rnd%0d", r), w, nb, 1'b0, 1'b0, 8'h00, em,
                     (nb == 8) ? 1 : 0, m_rx);
        end

`ifdef SPI_SLAVE_OVERRUN_EN
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
        chk("ovr_cleared_start", rx_overrun, 0);
        do_frame("ovr_a", 8'h0F, 8, 1'b0, 1'b0, 8'h00, 8'h00, 1, 8'h0F);
        chk("ovr_after_first", rx_overrun, 0);
        do_frame("ovr_b", 8'hF1, 8, 1'b0, 1'b0, 8'h00, 8'h00, 1, 8'hF1);
        chk("ovr_after_second", rx_overrun, 1);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk("ovr_after_ack", rx_overrun, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
